// File: rtl/gvt_reducer.sv
// gvt_reducer: periodic min-tree reduction of per-tile local VTs into a monotone GVT
module gvt_reducer #(
  parameter int N_TILES = 16,
  parameter int TS_WIDTH = 32,
  parameter int TB_WIDTH = 32,
  parameter int LOG_GVT_PERIOD = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [N_TILES*TS_WIDTH-1:0]  lvt_ts,
  input  logic [N_TILES*TB_WIDTH-1:0]  lvt_tb,
  input  logic [N_TILES-1:0]           lvt_valid,
  input  logic                         msgs_in_flight,
  input  logic                         err_clear,
  output logic [TS_WIDTH-1:0]          gvt_ts,
  output logic [TB_WIDTH-1:0]          gvt_tb,
  output logic                         gvt_valid,
  output logic                         all_idle,
  output logic                         gvt_regress_err,
  output logic [31:0]                  gvt_count
);
  localparam int L = (N_TILES > 1) ? $clog2(N_TILES) : 0;
  localparam int VT_W = TS_WIDTH + TB_WIDTH;
  function automatic int lvl_n(input int k);
    int n = N_TILES;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction
  if ((1 << LOG_GVT_PERIOD) < L + 3) begin : g_bad_period
    $error("gvt_reducer: reduction period shorter than min-tree latency");
  end
  logic [LOG_GVT_PERIOD-1:0] cnt;
  logic trig, any_v, mif, tv, grow, idle_pub, regress;
  logic [VT_W-1:0] gvt, m;
  assign trig = enable && (&cnt);
  // period counter, frozen while enable is low
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  // snapshot of activity flags; stable until the next trigger since only one reduction is in flight
  always_ff @(posedge clk)
    if (trig) begin
      any_v <= |lvt_valid;
      mif <= msgs_in_flight;
    end
  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int NK = lvl_n(k);
    logic [VT_W-1:0] lvl [NK];
    logic v;
    if (k == 0) begin : g_snap
      // stage 0: capture each tile's VT, idle tiles as all-ones
      always_ff @(posedge clk) begin
        v <= !rst && trig;
        for (int i = 0; i < NK; i++)
          if (trig) lvl[i] <= lvt_valid[i] ? {lvt_ts[i*TS_WIDTH +: TS_WIDTH], lvt_tb[i*TB_WIDTH +: TB_WIDTH]} : '1;
      end
    end else begin : g_min
      localparam int NP = lvl_n(k - 1);
      // pairwise minima; an odd leftover compares against itself and passes through
      always_ff @(posedge clk) begin
        v <= !rst && g_lvl[k-1].v;
        for (int j = 0; j < NK; j++)
          lvl[j] <= (g_lvl[k-1].lvl[(2*j+1 < NP) ? 2*j+1 : 2*j] < g_lvl[k-1].lvl[2*j]) ?
                    g_lvl[k-1].lvl[(2*j+1 < NP) ? 2*j+1 : 2*j] : g_lvl[k-1].lvl[2*j];
      end
    end
  end
  assign m = g_lvl[L].lvl[0];
  assign tv = g_lvl[L].v;
  assign grow = tv && any_v && (m >= gvt);
  assign regress = tv && any_v && (m < gvt);
  assign idle_pub = tv && !any_v && !mif;
  // publish stage: advance GVT, flag regressions, latch termination
  always_ff @(posedge clk)
    if (rst) begin
      gvt <= '0;
      gvt_valid <= 1'b0;
      all_idle <= 1'b0;
      gvt_regress_err <= 1'b0;
      gvt_count <= '0;
    end else begin
      gvt_valid <= grow || idle_pub;
      gvt <= grow ? m : idle_pub ? '1 : gvt;
      gvt_count <= gvt_count + {31'd0, grow || idle_pub};
      all_idle <= all_idle || idle_pub;
      gvt_regress_err <= regress || (gvt_regress_err && !err_clear);
    end
  assign {gvt_ts, gvt_tb} = gvt;
endmodule

// File: tb/tb_gvt_reducer.sv
// tb_gvt_reducer: directed checks of the GVT reduction pipeline
module tb_gvt_reducer;
  localparam int N = 16;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst, enable, msgs_in_flight, err_clear;
  logic [N*W-1:0] lvt_ts, lvt_tb;
  logic [N-1:0] lvt_valid;
  logic [W-1:0] gvt_ts, gvt_tb;
  logic gvt_valid, all_idle, gvt_regress_err;
  logic [31:0] gvt_count;
  int checks = 0;
  int errors = 0;
  int cur = 0;
  gvt_reducer #(.N_TILES(N), .TS_WIDTH(W), .TB_WIDTH(W), .LOG_GVT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .lvt_ts(lvt_ts), .lvt_tb(lvt_tb),
    .lvt_valid(lvt_valid), .msgs_in_flight(msgs_in_flight), .err_clear(err_clear),
    .gvt_ts(gvt_ts), .gvt_tb(gvt_tb), .gvt_valid(gvt_valid), .all_idle(all_idle),
    .gvt_regress_err(gvt_regress_err), .gvt_count(gvt_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: got %h expected %h", tag, cur, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask
  task automatic goto(input int c);
    while (cur < c) step();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur = 0;
  endtask
  task automatic set_all(input logic [W-1:0] ts, input logic [W-1:0] tb, input logic v);
    for (int i = 0; i < N; i++) begin
      lvt_ts[i*W +: W] = ts;
      lvt_tb[i*W +: W] = tb;
    end
    lvt_valid = {N{v}};
  endtask
  task automatic set_tile(input int i, input logic [W-1:0] ts, input logic [W-1:0] tb);
    lvt_ts[i*W +: W] = ts;
    lvt_tb[i*W +: W] = tb;
    lvt_valid[i] = 1'b1;
  endtask
  initial begin
    enable = 1'b1;
    msgs_in_flight = 1'b0;
    err_clear = 1'b0;
    set_all(0, 0, 0);
    do_reset();
    chk("rst_ts", gvt_ts, 0);
    chk("rst_tb", gvt_tb, 0);
    chk("rst_valid", gvt_valid, 0);
    chk("rst_idle", all_idle, 0);
    chk("rst_err", gvt_regress_err, 0);
    chk("rst_count", gvt_count, 0);
    for (int i = 0; i < N; i++) set_tile(i, 100 + i, 7);
    goto(36);
    chk("basic_early", gvt_valid, 0);
    goto(37);
    chk("basic_valid", gvt_valid, 1);
    chk("basic_ts", gvt_ts, 100);
    chk("basic_tb", gvt_tb, 7);
    chk("basic_count", gvt_count, 1);
    goto(38);
    chk("basic_pulse_end", gvt_valid, 0);
    chk("basic_hold", gvt_ts, 100);
    do_reset();
    set_all(60, 0, 1);
    set_tile(3, 50, 9);
    set_tile(9, 50, 2);
    goto(37);
    chk("tieb_ts", gvt_ts, 50);
    chk("tieb_tb", gvt_tb, 2);
    do_reset();
    set_all(300, 5, 1);
    set_tile(0, 200, 0);
    goto(37);
    chk("reg_first_valid", gvt_valid, 1);
    chk("reg_first_ts", gvt_ts, 200);
    chk("reg_first_tb", gvt_tb, 0);
    goto(40);
    set_tile(0, 150, 0);
    goto(69);
    chk("reg_no_pulse", gvt_valid, 0);
    chk("reg_hold_ts", gvt_ts, 200);
    chk("reg_err", gvt_regress_err, 1);
    chk("reg_count", gvt_count, 1);
    goto(70);
    err_clear = 1'b1;
    chk("reg_err_sticky", gvt_regress_err, 1);
    step();
    err_clear = 1'b0;
    chk("reg_err_cleared", gvt_regress_err, 0);
    goto(100);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("reg_set_wins", gvt_regress_err, 1);
    chk("reg_hold_ts2", gvt_ts, 200);
    do_reset();
    set_all(0, 0, 0);
    msgs_in_flight = 1'b1;
    goto(32);
    msgs_in_flight = 1'b0;
    goto(37);
    chk("veto_no_pulse", gvt_valid, 0);
    chk("veto_idle", all_idle, 0);
    chk("veto_count", gvt_count, 0);
    goto(69);
    chk("term_valid", gvt_valid, 1);
    chk("term_idle", all_idle, 1);
    chk("term_ts", gvt_ts, 32'hffff_ffff);
    chk("term_tb", gvt_tb, 32'hffff_ffff);
    chk("term_count", gvt_count, 1);
    goto(70);
    set_tile(0, 5, 5);
    goto(101);
    chk("idle_sticky", all_idle, 1);
    chk("idle_no_pulse", gvt_valid, 0);
    chk("idle_err", gvt_regress_err, 1);
    chk("idle_gvt", gvt_ts, 32'hffff_ffff);
    do_reset();
    set_all(20, 0, 1);
    set_tile(5, 10, 0);
    goto(32);
    set_tile(5, 5, 0);
    goto(33);
    enable = 1'b0;
    goto(37);
    chk("samp_valid", gvt_valid, 1);
    chk("samp_ts", gvt_ts, 10);
    chk("samp_tb", gvt_tb, 0);
    goto(100);
    chk("frozen_count", gvt_count, 1);
    set_all(30, 0, 1);
    enable = 1'b1;
    goto(135);
    chk("resume_early", gvt_valid, 0);
    goto(136);
    chk("resume_valid", gvt_valid, 1);
    chk("resume_ts", gvt_ts, 30);
    chk("resume_count", gvt_count, 2);
    do_reset();
    for (int i = 0; i < N; i++) set_tile(i, 100 + i, 7);
    goto(34);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ts", gvt_ts, 0);
    chk("midrst_count", gvt_count, 0);
    goto(37);
    chk("midrst_no_pub", gvt_valid, 0);
    chk("midrst_ts2", gvt_ts, 0);
    goto(72);
    chk("midrst_recover", gvt_valid, 1);
    chk("midrst_recover_ts", gvt_ts, 100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
